// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/load-store memory port arbiter: access sizes,
// FSM states and requester select.
package mem_arb_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        SEL_IF,
        SEL_D
    } sel_e;

endpackage

// File: rtl/mem_lane.sv
// Combinational byte-lane logic: store lane mask and replication, load lane
// selection with sign/zero extension, and misalignment detection.
module mem_lane
    import mem_arb_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  we_mask,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        we_mask   = 4'b0000;
        wdata_al  = '0;
        rdata_ext = '0;
        misalign  = 1'b0;
        case (size)
            SZ_B: begin
                we_mask   = 4'b0001 << addr_lo;
                wdata_al  = {4{wdata[7:0]}};
                rdata_ext = {{24{sign & rd_byte[7]}}, rd_byte};
            end
            SZ_H: begin
                we_mask   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al  = {2{wdata[15:0]}};
                rdata_ext = {{16{sign & rd_half[15]}}, rd_half};
                misalign  = addr_lo[0];
            end
            SZ_W: begin
                we_mask   = 4'b1111;
                wdata_al  = wdata;
                rdata_ext = rdata;
                misalign  = |addr_lo;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-port RAM.
// Define ARB_FAIR_EN to bound how long fetch can be starved by data traffic.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned RAM_AW     = 14,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_sign,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e           state_q, state_d;
    sel_e             sel_q, sel_d;
    logic             we_q, we_d;
    logic [1:0]       lo_q, size_q;
    logic             sign_q;
    logic [LAT_W-1:0] lat_q, lat_d;

    logic        pick_if, fetch_wins, grant;
    logic [31:0] gaddr;
    logic [1:0]  lane_size;
    logic        lane_sign;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata_al, lane_rdata;
    logic        misalign;
    logic        resp_d, err_now, to_if, to_d;
    logic        unused_addr;

`ifdef ARB_FAIR_EN
    localparam int unsigned STV_W =
        ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    logic [STV_W-1:0] starve_q;
    assign fetch_wins = (starve_q == STV_W'(STARVE_MAX));
`else
    assign fetch_wins = 1'b0;
`endif

    assign pick_if = if_req && (!d_req || fetch_wins);
    assign grant   = (state_q == IDLE) && (if_req || d_req);

    // In IDLE the lane logic looks at the live request; afterwards at the latched one.
    always_comb begin
        gaddr      = {30'b0, lo_q};
        lane_size  = size_q;
        lane_sign  = sign_q;
        lane_wdata = '0;
        we_d       = we_q;
        sel_d      = sel_q;
        if (state_q == IDLE) begin
            if (pick_if) begin
                gaddr     = if_addr;
                lane_size = SZ_W;
                lane_sign = 1'b0;
                we_d      = 1'b0;
                sel_d     = SEL_IF;
            end else begin
                gaddr      = d_addr;
                lane_size  = d_size;
                lane_sign  = d_sign;
                lane_wdata = d_wdata;
                we_d       = d_we;
                sel_d      = SEL_D;
            end
        end
    end

    assign unused_addr = ^gaddr[31:RAM_AW+2];

    mem_lane u_lane (
        .addr_lo   (gaddr[1:0]),
        .size      (lane_size),
        .sign      (lane_sign),
        .wdata     (lane_wdata),
        .rdata     (ram_rdata),
        .we_mask   (lane_mask),
        .wdata_al  (lane_wdata_al),
        .rdata_ext (lane_rdata),
        .misalign  (misalign)
    );

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE:  if (if_req || d_req) state_d = misalign ? RESP : ISSUE;
            ISSUE: begin
                state_d = we_q ? RESP : WAIT;
                lat_d   = LAT_W'(RD_LAT - 1);
            end
            WAIT: begin
                if (lat_q == '0) state_d = RESP;
                else             lat_d   = lat_q - LAT_W'(1);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only the IDLE->RESP path carries an error, so err is decided at grant time.
    assign resp_d  = (state_d == RESP);
    assign err_now = (state_q == IDLE) && misalign;
    assign to_if   = resp_d && (sel_d == SEL_IF);
    assign to_d    = resp_d && (sel_d == SEL_D);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sel_q     <= SEL_IF;
            we_q      <= 1'b0;
            lo_q      <= 2'b00;
            size_q    <= SZ_B;
            sign_q    <= 1'b0;
            lat_q     <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 4'b0000;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (grant) begin
                sel_q     <= sel_d;
                we_q      <= we_d;
                lo_q      <= gaddr[1:0];
                size_q    <= lane_size;
                sign_q    <= lane_sign;
                ram_addr  <= gaddr[RAM_AW+1:2];
                ram_wdata <= lane_wdata_al;
            end
            ram_en   <= (state_d == ISSUE);
            ram_we   <= ((state_d == ISSUE) && we_d) ? lane_mask : 4'b0000;
            if_ack   <= to_if;
            if_err   <= to_if && err_now;
            if_rdata <= (to_if && !err_now) ? lane_rdata : '0;
            d_ack    <= to_d;
            d_err    <= to_d && err_now;
            d_rdata  <= (to_d && !err_now && !we_d) ? lane_rdata : '0;
        end
    end

`ifdef ARB_FAIR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else if (grant) begin
            if (pick_if)                   starve_q <= '0;
            else if (if_req && !fetch_wins) starve_q <= starve_q + STV_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter with a one-cycle-latency RAM model.
module tb_mem_port_arbiter;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = '0;
    logic          if_ack;
    logic [31:0]   if_rdata;
    logic          if_err;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [1:0]    d_size = 2'd0;
    logic          d_sign = 1'b0;
    logic [31:0]   d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic          d_ack;
    logic [31:0]   d_rdata;
    logic          d_err;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = '0;

    int n_chk  = 0;
    int n_miss = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_size    (d_size),
        .d_sign    (d_sign),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: 64 words, preloaded while reset is held, read latency 1.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8C220004;
            mem[8] <= 32'h80FF7F01;
        end else if (ram_en) begin
            if (ram_we == 4'b0000) begin
                ram_rdata <= mem[ram_addr[5:0]];
            end else begin
                for (int l = 0; l < 4; l++)
                    if (ram_we[l]) mem[ram_addr[5:0]][8*l +: 8] <= ram_wdata[8*l +: 8];
            end
        end
    end

    typedef struct {
        logic        fetch;
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  mask;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({if_ack, if_err, d_ack, d_err, ram_en, ram_we}) | if_rdata | d_rdata
             | ram_wdata | 32'(ram_addr);
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int k = 0, en_cnt = 0, en_k = -1, ack_k = -1;
        logic        got_err = 1'b0, other = 1'b0, noisy = 1'b0;
        logic [31:0] got_rd = '0, seen_wd = '0, seen_addr = '0;
        logic [3:0]  seen_we = '0;
        logic        ack, err;
        logic [31:0] rd;
        string       tag;
        tag = $sformatf("v%0d", idx);
        @(posedge clk); #1;
        if (v.fetch) begin
            if_addr = v.addr; if_req = 1'b1;
        end else begin
            d_addr = v.addr; d_we = v.we; d_size = v.size; d_sign = v.sign;
            d_wdata = v.wdata; d_req = 1'b1;
        end
        while (ack_k < 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
            ack = v.fetch ? if_ack : d_ack;
            err = v.fetch ? if_err : d_err;
            rd  = v.fetch ? if_rdata : d_rdata;
            if (v.fetch ? d_ack : if_ack) other = 1'b1;
            if (!ram_en && ram_we != 4'b0000) noisy = 1'b1;
            if (!ack && (err || rd != 32'h0)) noisy = 1'b1;
            if (ram_en) begin
                en_cnt++; en_k = k;
                seen_we = ram_we; seen_wd = ram_wdata; seen_addr = 32'(ram_addr);
            end
            if (ack) begin
                ack_k = k; got_err = err; got_rd = rd;
                if_req = 1'b0; d_req = 1'b0;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        check({tag, " ack_cycle"}, 32'(ack_k), 32'(v.lat));
        check({tag, " err"}, 32'(got_err), 32'(v.err));
        check({tag, " rdata"}, got_rd, v.rdata);
        check({tag, " other_ack/idle_noise"}, 32'({other, noisy}), 32'h0);
        check({tag, " ram_en_count"}, 32'(en_cnt), v.err ? 32'd0 : 32'd1);
        if (!v.err) begin
            check({tag, " ram_en_cycle"}, 32'(en_k), 32'd1);
            check({tag, " ram_addr"}, seen_addr, v.addr >> 2);
            check({tag, " ram_we"}, 32'(seen_we), 32'(v.mask));
            if (v.we) check({tag, " ram_wdata"}, seen_wd, v.wd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_cnt, if_cnt, d_before;

        //         fetch we  size sign addr      wdata        lat err rdata         mask     wd
        tbl[0]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        3, 1'b0, 32'h8C220004, 4'b0000, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h23, 32'h0,        3, 1'b0, 32'hFFFFFF80, 4'b0000, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h23, 32'h0,        3, 1'b0, 32'h00000080, 4'b0000, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        3, 1'b0, 32'h000080FF, 4'b0000, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h06, 32'h1234ABCD, 2, 1'b0, 32'h0, 4'b1100, 32'hABCDABCD};
        tbl[5]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h06, 32'h0,        3, 1'b0, 32'h0000ABCD, 4'b0000, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h06, 32'h0,        3, 1'b0, 32'hFFFFABCD, 4'b0000, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h09, 32'h00000055, 2, 1'b0, 32'h0, 4'b0010, 32'h55555555};
        tbl[8]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        3, 1'b0, 32'h00005500, 4'b0000, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0C, 32'hDEADBEEF, 2, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF};
        tbl[10] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0,        3, 1'b0, 32'hDEADBEEF, 4'b0000, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h22, 32'h0,        3, 1'b0, 32'hFFFFFFFF, 4'b0000, 32'h0};
        tbl[12] = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        3, 1'b0, 32'hFFFF80FF, 4'b0000, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h21, 32'h0,        3, 1'b0, 32'h0000007F, 4'b0000, 32'h0};
        tbl[14] = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h20, 32'h0,        3, 1'b0, 32'h00007F01, 4'b0000, 32'h0};
        tbl[15] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h05, 32'h0,        1, 1'b1, 32'h0, 4'b0000, 32'h0};
        tbl[16] = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h07, 32'h0,        1, 1'b1, 32'h0, 4'b0000, 32'h0};
        tbl[17] = '{1'b0, 1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        1, 1'b1, 32'h0, 4'b0000, 32'h0};
        tbl[18] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h12, 32'h0,        1, 1'b1, 32'h0, 4'b0000, 32'h0};
        tbl[19] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h01, 32'h0000FFFF, 1, 1'b1, 32'h0, 4'b0000, 32'h0};
        tbl[20] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        3, 1'b0, 32'h80FF7F01, 4'b0000, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 21; i++) run_vec(i, tbl[i]);

        // Reset during WAIT: outputs clear immediately, the late RAM word is dropped.
        @(posedge clk); #1;
        if_addr = 32'h10; if_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("reset_in_wait_outputs", all_outs(), 32'h0);
        if_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        if_cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (if_ack || d_ack) if_cnt++;
        end
        check("no_stale_ack", 32'(if_cnt), 32'h0);
        run_vec(100, tbl[0]);

        // Both requesters held high continuously.
        @(posedge clk); #1;
        if_addr = 32'h10; if_req = 1'b1;
        d_addr = 32'h0C; d_we = 1'b0; d_size = 2'd2; d_sign = 1'b0; d_req = 1'b1;
        d_cnt = 0; if_cnt = 0; d_before = -1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (if_ack) begin
                if (if_cnt == 0) d_before = d_cnt;
                if_cnt++;
            end
            if (d_ack) d_cnt++;
        end
        if_req = 1'b0; d_req = 1'b0;
`ifdef ARB_FAIR_EN
        check("fair_data_grants_before_fetch", 32'(d_before), 32'd4);
`else
        check("strict_fetch_grants", 32'(if_cnt), 32'd0);
        check("strict_data_grants", 32'(d_cnt), 32'd15);
`endif
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous single-port RAM between two requesters: the instruction fetch unit and the load/store unit (lb/lh/lw/lbu/lhu/sb/sh/sw).
- Handles arbitration, the RAM access sequence, read-latency counting, byte-lane alignment, sign/zero extension and misalignment detection.
- Sits between the core datapath and the unified memory. Memory is little-endian. Byte address bits [1:0] select the lane.

Parameters:
- RAM_AW, 14, word-address width of the RAM port.
- RD_LAT, 1, RAM read latency in cycles (≥1); ram_rdata is valid RD_LAT cycles after a cycle with ram_en=1 and ram_we=0.
- STARVE_MAX, 4, number of consecutive data grants allowed while fetch waits (used only with ARB_FAIR_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  32  fetch byte address.
- if_ack  out  1  one-cycle pulse: fetch done.
- if_rdata  out  32  instruction word; valid while if_ack=1.
- if_err  out  1  with if_ack: misaligned fetch.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1=store, 0=load.
- d_size  in  2  0=byte, 1=half, 2=word; 3 is illegal (treated as misaligned).
- d_sign  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-justified.
- d_ack  out  1  one-cycle pulse: data access done.
- d_rdata  out  32  extended load result; valid while d_ack=1.
- d_err  out  1  with d_ack: misaligned or illegal size.
- ram_en  out  1  RAM access strobe.
- ram_we  out  4  byte-lane write enables; lane i = bits [8i+7:8i].
- ram_addr  out  RAM_AW  word address = byte addr[RAM_AW+1:2].
- ram_wdata  out  32  lane-aligned store data.
- ram_rdata  in  32  RAM read data.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, starve counter 0. Reset mid-access aborts the access with no ack; late ram_rdata is ignored.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Arbitration in IDLE (cycle N):
  - Only one of d_req/if_req high: grant it.
  - Both high: data wins, unless the fairness rule overrides.
  - Grant latches the requester's address, size, sign, we and wdata.
- Misalignment check:
  - Error cases: half with addr[0]=1; word with addr[1:0]≠0; d_size=3; fetch with if_addr[1:0]≠0.
  - On error: IDLE→RESP; ack and err are high in N+1; ram_en stays 0.
- Store: IDLE→ISSUE→RESP.
  - ISSUE (N+1): ram_en=1, ram_we = lane mask.
  - Lane masks: byte = 1<<addr[1:0]; half = 0011 or 1100; word = 1111.
  - ram_wdata: byte value replicated to all four lanes; half value replicated to both halves.
  - ack in N+2.
- Load/fetch: IDLE→ISSUE→WAIT→RESP.
  - ISSUE (N+1): ram_en=1, ram_we=0.
  - WAIT lasts RD_LAT cycles; ram_rdata is captured on the last one.
  - RESP in N+2+RD_LAT: ack=1, and rdata is the selected lane, extended per d_sign.
  - Fetch returns the full word.
- RESP: ack is high for exactly one cycle, then the FSM goes to IDLE.
  - A requester must drop req or present a new request in the cycle after ack.
  - The earliest back-to-back grant is the cycle after RESP.
- ram_en is high only in ISSUE. ram_we is 0 outside ISSUE.
- Only the granted requester's ack/rdata/err may change. rdata/err return to 0 when ack is low.
- A req deasserted before its ack is a protocol violation; the in-flight access completes regardless.

Optional Feature:
- Macro: ARB_FAIR_EN.
- With it defined:
  - A 3-bit-or-wider starve counter increments on each data grant made while if_req=1.
  - It clears on any fetch grant.
  - When counter==STARVE_MAX and both requests are high, fetch is granted.
- Without it: strict data priority and no counter logic.

Decomposition:
- Package mem_arb_pkg holds:
  - size constants SZ_B, SZ_H, SZ_W;
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the requester-select typedef (SEL_IF, SEL_D).
- Sub-module mem_lane (combinational): given addr[1:0], size, sign, wdata and rdata, produces ram_we mask, aligned wdata, extended load data and the misalign flag.
- The FSM, latency counter and arbitration stay in the top module.

Test Plan:
- Fetch alone, if_addr=0x10, RAM word 4 = 0x8C220004, RD_LAT=1 → ram_en at N+1 with ram_addr=4; if_ack at N+3 with if_rdata=0x8C220004.
- lb, d_addr=0x23, sign=1, RAM word 8 = 0x80FF7F01 → d_rdata=0xFFFFFF80. lbu at the same address → 0x00000080. lhu at 0x22 → 0x000080FF.
- sh, d_addr=0x06, d_wdata=0x1234ABCD → ram_we=1100, ram_wdata=0xABCDABCD, ram_addr=1; d_ack at N+2.
- lw at 0x05 → d_ack+d_err at N+1, ram_en never 1, d_rdata=0.
- if_req and d_req held continuously: without ARB_FAIR_EN fetch is never granted; with it, fetch is granted after exactly STARVE_MAX=4 data grants.
- reset_n low during WAIT → all outputs 0 immediately. After release, a new fetch completes normally and no stale ack is produced.
